// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and helpers for the fetch realignment stage
package rv_fetch_pkg;

  typedef logic [15:0] halfword_t;

  // Low two bits of a halfword that mark a full-length (32-bit) instruction
  localparam logic [1:0]  RVC_FULL_LEN     = 2'b11;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic is_32bit(input halfword_t hw);
    return hw[1:0] == RVC_FULL_LEN;
  endfunction

endpackage

// File: rtl/fetch_align_buffer_if.sv
// rtl/fetch_align_buffer_if.sv - I-cache, redirect and instruction handshake bundle
interface fetch_align_buffer_if;

  logic        ic_req;
  logic [29:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_is_c;
  logic [31:0] inst_pc;
  logic        inst_ready;

  // The fetch buffer side
  modport master (
    output ic_req, ic_addr, inst_valid, inst, inst_is_c, inst_pc,
    input  ic_rdata, ic_stall, redirect_valid, redirect_pc, inst_ready
  );

  // The I-cache / decode / branch-unit side
  modport slave (
    input  ic_req, ic_addr, inst_valid, inst, inst_is_c, inst_pc,
    output ic_rdata, ic_stall, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_hq.sv
// rtl/fetch_hq.sv - 4-entry halfword queue, pop-then-push each cycle, sync flush
module fetch_hq
  import rv_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic [1:0] pop_n_i,
  input  logic [1:0] push_n_i,
  input  halfword_t  push_d0_i,
  input  halfword_t  push_d1_i,
  output logic [2:0] count_o,
  output halfword_t  hq0_o,
  output halfword_t  hq1_o
);

  halfword_t  q_q [4];
  halfword_t  q_d [4];
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic [2:0] cnt_mid;
  logic [2:0] idx;
  halfword_t  shifted;

  // Shift out popped entries, then append pushed halfwords behind the survivors
  always_comb begin
    cnt_mid = cnt_q - {1'b0, pop_n_i};
    idx     = 3'd0;
    shifted = '0;
    for (int i = 0; i < 4; i++) begin
      idx     = 3'(i) + {1'b0, pop_n_i};
      shifted = (idx < 3'd4) ? q_q[idx[1:0]] : '0;
      if (3'(i) < cnt_mid) begin
        q_d[i] = shifted;
      end else if ((3'(i) == cnt_mid) && (push_n_i != 2'd0)) begin
        q_d[i] = push_d0_i;
      end else if ((3'(i) == cnt_mid + 3'd1) && (push_n_i == 2'd2)) begin
        q_d[i] = push_d1_i;
      end else begin
        q_d[i] = shifted;
      end
    end
    cnt_d = cnt_mid + {1'b0, push_n_i};
    if (flush_i) begin
      cnt_d = 3'd0;
    end
  end

  // Queue storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < 4; i++) begin
        q_q[i] <= q_d[i];
      end
    end
  end

  assign count_o = cnt_q;
  assign hq0_o   = q_q[0];
  assign hq1_o   = q_q[1];

endmodule

// File: rtl/fetch_align_buffer.sv
// rtl/fetch_align_buffer.sv - realigns I-cache words into whole RV instructions
module fetch_align_buffer
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_align_buffer_if.master bus
);

  logic [29:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] out_pc_q,     out_pc_d;
  logic        skip_low_q,   skip_low_d;

  logic [2:0]  count;
  halfword_t   hq0, hq1;
  logic        is32;
  logic [2:0]  need;
  logic        fire;
  logic        push;
  logic [1:0]  pop_n;
  logic [1:0]  push_n;
  halfword_t   push_d0;
  logic        unused_pc_bit0;

  assign unused_pc_bit0 = bus.redirect_pc[0];

  assign is32 = is_32bit(hq0);
  assign need = is32 ? 3'd2 : 3'd1;

  // A redirect masks the current head so decode never sees a doomed instruction
  assign bus.inst_valid = !bus.redirect_valid && (count >= need);
  assign bus.inst       = is32 ? {hq1, hq0} : {16'h0000, hq0};
  assign bus.inst_is_c  = (count != 3'd0) && !is32;
  assign bus.inst_pc    = out_pc_q;
  assign fire           = bus.inst_valid && bus.inst_ready;

  // Only request while two free slots exist, so a whole word always fits
  assign bus.ic_req  = rst_n && (count <= 3'd2) && !bus.redirect_valid;
  assign bus.ic_addr = fetch_addr_q;
  assign push        = bus.ic_req && !bus.ic_stall;

  assign pop_n   = fire ? (is32 ? 2'd2 : 2'd1) : 2'd0;
  assign push_n  = push ? (skip_low_q ? 2'd1 : 2'd2) : 2'd0;
  assign push_d0 = skip_low_q ? bus.ic_rdata[31:16] : bus.ic_rdata[15:0];

  fetch_hq u_hq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (bus.redirect_valid),
    .pop_n_i   (pop_n),
    .push_n_i  (push_n),
    .push_d0_i (push_d0),
    .push_d1_i (bus.ic_rdata[31:16]),
    .count_o   (count),
    .hq0_o     (hq0),
    .hq1_o     (hq1)
  );

  // Next fetch address, delivered PC and half-word skip; redirect overrides all
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    out_pc_d     = out_pc_q;
    skip_low_d   = skip_low_q;
    if (bus.redirect_valid) begin
      fetch_addr_d = bus.redirect_pc[31:2];
      out_pc_d     = {bus.redirect_pc[31:1], 1'b0};
      skip_low_d   = bus.redirect_pc[1];
    end else begin
      if (push) begin
        fetch_addr_d = fetch_addr_q + 30'd1;
        skip_low_d   = 1'b0;
      end
      if (fire) begin
        out_pc_d = out_pc_q + (is32 ? 32'd4 : 32'd2);
      end
    end
  end

  // PC and fetch-address state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q <= RESET_PC[31:2];
      out_pc_q     <= {RESET_PC[31:1], 1'b0};
      skip_low_q   <= RESET_PC[1];
    end else begin
      fetch_addr_q <= fetch_addr_d;
      out_pc_q     <= out_pc_d;
      skip_low_q   <= skip_low_d;
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// tb/tb_fetch_align_buffer.sv - directed self-checking bench for fetch_align_buffer
module tb_fetch_align_buffer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [31:0] mem [128];

  fetch_align_buffer_if bus();

  fetch_align_buffer #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.ic_rdata = mem[bus.ic_addr[6:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1);
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[0] = w0;
    mem[1] = w1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ic_req"},    {31'h0, bus.ic_req},     32'h0);
    check({tag, "_ic_addr"},   {2'b00, bus.ic_addr},    32'h0);
    check({tag, "_valid"},     {31'h0, bus.inst_valid}, 32'h0);
    check({tag, "_inst"},      bus.inst,                32'h0);
    check({tag, "_is_c"},      {31'h0, bus.inst_is_c},  32'h0);
    check({tag, "_pc"},        bus.inst_pc,             32'h0);
  endtask

  task automatic do_reset(input bit check_in_reset);
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    @(negedge clk);
    #1;
    if (check_in_reset) check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic check_inst(input string tag, input logic [31:0] exp_inst,
                            input logic [31:0] exp_pc, input logic exp_c);
    check({tag, "_valid"}, {31'h0, bus.inst_valid}, 32'h1);
    check({tag, "_inst"},  bus.inst,                exp_inst);
    check({tag, "_pc"},    bus.inst_pc,             exp_pc);
    check({tag, "_is_c"},  {31'h0, bus.inst_is_c},  {31'h0, exp_c});
  endtask

  initial begin
    n_checks           = 0;
    n_errors           = 0;
    rst_n              = 1'b1;
    bus.ic_stall       = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    load(32'h0, 32'h0);
    #2;

    // Single 32-bit instruction, one cycle of fetch latency
    load(32'h00A0_0093, 32'h0001_0001);
    bus.inst_ready = 1'b1;
    do_reset(1'b1);
    check("t1_req_first", {31'h0, bus.ic_req}, 32'h1);
    check("t1_addr_first", {2'b00, bus.ic_addr}, 32'h0);
    tick();
    check_inst("t1", 32'h00A0_0093, 32'h0, 1'b0);

    // Two compressed halfwords from one word
    load(32'h4505_0085, 32'h0001_0001);
    bus.inst_ready = 1'b1;
    do_reset(1'b0);
    tick();
    check_inst("t2a", 32'h0000_0085, 32'h0, 1'b1);
    tick();
    check_inst("t2b", 32'h0000_4505, 32'h2, 1'b1);
    check("t2_full_noreq", {31'h0, bus.ic_req}, 32'h0);

    // 32-bit instruction straddling a word boundary
    load(32'h0093_4505, 32'h1234_00A0);
    bus.inst_ready = 1'b1;
    bus.ic_stall   = 1'b0;
    do_reset(1'b0);
    tick();
    check_inst("t3a", 32'h0000_4505, 32'h0, 1'b1);
    tick();
    check_inst("t3b", 32'h00A0_0093, 32'h2, 1'b0);
    bus.ic_stall = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    check_inst("t3c", 32'h0000_1234, 32'h6, 1'b1);
    check("t3_addr", {2'b00, bus.ic_addr}, 32'h2);
    tick();
    check_inst("t3d", 32'h0000_1234, 32'h6, 1'b1);
    bus.ic_stall = 1'b0;

    // Redirect to 0x106 with three halfwords queued: low half of word 0x41 dropped
    load(32'h0093_4505, 32'h1234_00A0);
    mem[7'h41] = 32'h8082_FFFF;
    bus.inst_ready = 1'b1;
    do_reset(1'b0);
    tick();
    tick();
    check("t4_pre_pc", bus.inst_pc, 32'h2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0106;
    #1;
    check("t4_rd_valid", {31'h0, bus.inst_valid}, 32'h0);
    check("t4_rd_req",   {31'h0, bus.ic_req},     32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("t4_addr", {2'b00, bus.ic_addr}, 32'h41);
    check("t4_empty", {31'h0, bus.inst_valid}, 32'h0);
    tick();
    check_inst("t4", 32'h0000_8082, 32'h106, 1'b1);

    // Stall for 5 cycles with decode idle
    load(32'h00A0_0093, 32'h0001_0001);
    bus.ic_stall   = 1'b1;
    bus.inst_ready = 1'b0;
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) begin
      check("t5_stall_req",   {31'h0, bus.ic_req},     32'h1);
      check("t5_stall_addr",  {2'b00, bus.ic_addr},    32'h0);
      check("t5_stall_valid", {31'h0, bus.inst_valid}, 32'h0);
      tick();
    end
    bus.ic_stall = 1'b0;
    tick();
    check_inst("t5", 32'h00A0_0093, 32'h0, 1'b0);
    check("t5_addr_next", {2'b00, bus.ic_addr}, 32'h1);

    // Asynchronous reset mid-stream with three halfwords queued
    load(32'h0093_4505, 32'h1234_00A0);
    bus.inst_ready = 1'b1;
    do_reset(1'b0);
    tick();
    tick();
    check("t6_pre_pc", bus.inst_pc, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_restart_req",  {31'h0, bus.ic_req},  32'h1);
    check("t6_restart_addr", {2'b00, bus.ic_addr}, 32'h0);
    tick();
    check_inst("t6", 32'h0000_4505, 32'h0, 1'b1);

    // Redirect to the top halfword of the address space: PC and fetch address wrap
    load(32'h0001_0001, 32'h0001_0001);
    mem[127] = 32'h0001_FFFF;
    bus.ic_stall   = 1'b1;
    bus.inst_ready = 1'b0;
    do_reset(1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    bus.ic_stall       = 1'b0;
    bus.inst_ready     = 1'b1;
    #1;
    check("t7_addr_top", {2'b00, bus.ic_addr}, 32'h3FFF_FFFF);
    tick();
    check_inst("t7", 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    check("t7_addr_wrap", {2'b00, bus.ic_addr}, 32'h0);
    tick();
    check("t7_pc_wrap", bus.inst_pc, 32'h0);

    // 32-bit head with only its low half queued waits for the next word
    load(32'h0093_1111, 32'h1234_00A0);
    bus.ic_stall   = 1'b1;
    bus.inst_ready = 1'b1;
    do_reset(1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0002;
    tick();
    bus.redirect_valid = 1'b0;
    bus.ic_stall       = 1'b0;
    tick();
    bus.ic_stall = 1'b1;
    check("t8_partial_valid", {31'h0, bus.inst_valid}, 32'h0);
    check("t8_partial_addr",  {2'b00, bus.ic_addr},    32'h1);
    tick();
    check("t8_partial_hold", {31'h0, bus.inst_valid}, 32'h0);
    bus.ic_stall = 1'b0;
    tick();
    check_inst("t8", 32'h00A0_0093, 32'h2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_align_buffer.md
# fetch_align_buffer

Instruction realignment stage between the I-cache CPU port and the RISC-V decode stage. Fetches aligned 32-bit words from the I-cache, queues them as 16-bit halfwords, and presents whole instructions: 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary. Each instruction is delivered with its PC over a valid/ready handshake. Handles branch/jump redirects to any halfword-aligned PC. Decompression happens downstream.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 is 0.

- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- ic_req  output  1  read request to I-cache
- ic_addr  output  30  word address (PC[31:2]) of the request
- ic_rdata  input  32  fetched word; valid when ic_req=1 and ic_stall=0
- ic_stall  input  1  I-cache busy or missing; data not valid this cycle
- redirect_valid  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  32  new PC; bit 0 ignored (treated as 0)
- inst_valid  output  1  inst/inst_pc hold a complete instruction
- inst  output  32  instruction; compressed form is {16'h0, hw}
- inst_is_c  output  1  inst is a 16-bit compressed instruction
- inst_pc  output  32  PC of inst
- inst_ready  input  1  decode accepts inst this cycle

## Operation
- Halfword queue: 4 entries (hq0 is oldest) plus a count in the range 0..4. Registers: fetch_addr[29:0], out_pc[31:0], skip_low.
- Length rule: hq0[1:0]==2'b11 means a 32-bit instruction (needs 2 halfwords). Otherwise it is a 16-bit instruction (needs 1).
- inst_valid = !redirect_valid && count >= need.
- inst = is_c ? {16'h0, hq0} : {hq1, hq0}. inst_pc = out_pc.
- fire = inst_valid && inst_ready. On fire:
  - pop `need` halfwords;
  - out_pc += 2 (compressed) or 4 (32-bit).
- ic_req = (count <= 2) && !redirect_valid. ic_addr = fetch_addr.
- push = ic_req && !ic_stall. On push:
  - append ic_rdata[15:0] then ic_rdata[31:16]. If skip_low=1, append only [31:16] and clear skip_low.
  - fetch_addr += 1.
- Push and pop in the same cycle: pop happens first, then push is appended. count_next = count - pops + pushes.
- Redirect (highest priority):
  - queue count := 0;
  - fetch_addr := redirect_pc[31:2]; out_pc := {redirect_pc[31:1], 1'b0}; skip_low := redirect_pc[1];
  - any same-cycle push or fire is discarded.
- Arithmetic: out_pc and fetch_addr wrap modulo 2^32 and 2^30.

## Timing
- Reset (async, rst_n=0):
  - count=0; fetch_addr=RESET_PC[31:2]; out_pc=RESET_PC; skip_low=RESET_PC[1].
  - Outputs: ic_req=0 while held in reset, inst_valid=0, inst=0, inst_is_c=0, inst_pc=RESET_PC.
- First cycle after reset release: ic_req=1.
- Cache hit (ic_stall=0): the word is pushed at the clock edge. inst_valid rises the next cycle, i.e. 1 cycle of fetch latency.
- ic_stall=1: ic_req stays high and ic_addr is held stable until a cycle with ic_stall=0. The queue may drain in the meantime; it never grows.
- Redirect while stalled: ic_addr switches the next cycle. Stale data is never pushed, because pushes are gated by the current ic_addr.
- Full: count≥3 means ic_req=0. A queue overflow is impossible by construction.
- Empty or partial: a 32-bit instruction held with only hq0 present keeps inst_valid=0 until the upper half arrives.
- Sustained throughput: one instruction per cycle for any mix, given ic_stall=0.
- inst/inst_pc are stable while inst_valid=1 and inst_ready=0, unless a redirect occurs.

## Structure
- Shared package `rv_fetch_pkg`:
  - halfword typedef (16 bit);
  - constant RVC_FULL_LEN = 2'b11;
  - function is_32bit(halfword);
  - RESET_PC default constant.
- One sub-module `fetch_hq`: the 4×16 halfword queue with push-1/push-2 and pop-1/pop-2 ports, count output and synchronous flush.
- The top level holds the PC/fetch-address registers and the handshake logic.

## Test plan
- Reset with RESET_PC=0; cache returns 0x00A00093 at word 0; inst_ready=1 → ic_req=1 in the first cycle; the next cycle gives inst_valid=1, inst=0x00A00093, inst_is_c=0, inst_pc=0.
- Word 0 = 0x4505_0085 (two compressed halfwords) → two instructions on consecutive cycles: inst=0x0000_0085 at pc 0, then 0x0000_4505 at pc 2, both with inst_is_c=1.
- Straddle: word0 = 0x0093_4505, word1 = 0x1234_00A0 → c-inst 0x4505 at pc 0, then the 32-bit 0x00A0_0093 at pc 2; the remaining halfword 0x1234 stays at count=1.
- Redirect to 0x0000_0106 while the queue holds 3 halfwords → the next ic_addr is 0x41; the low half of the returned word is dropped; the first instruction is delivered at pc 0x106.
- ic_stall held high for 5 cycles with inst_ready=0 → ic_addr is stable throughout and no push occurs; release → the word is pushed and inst_valid follows in 1 cycle.
- rst_n asserted mid-stream with count=3 → all outputs return to their reset values asynchronously; after release, fetch restarts at RESET_PC.
